mbist_march_ctrl: RTL
=====================

# mbist_march_ctrl

Built-in self-test controller that acts as the initiator on the 4x4 SRAM's write/read port. On a start pulse it runs a March C- sequence over all words, compares every read against the expected background and reports pass/fail with first-failure diagnostics. It sits between the SoC test interface and the SRAM: in test mode its outputs drive the SRAM's data_in/addr/write_en and it consumes the SRAM's data_out.

## Interface
- ADDR_W, 2, SRAM address width (words = 2**ADDR_W)
- DATA_W, 4, SRAM word width
- STOP_ON_FAIL, 0, 1 = abort the test at the first read mismatch

- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- mem_dout  in  DATA_W  SRAM data_out (combinational read of addressed word)
- mem_din  out  DATA_W  SRAM data_in
- mem_addr  out  ADDR_W  SRAM address
- mem_we  out  1  SRAM write enable
- busy  out  1  test in progress
- done  out  1  level; high from test end until next accepted start
- fail  out  1  sticky; any mismatch in current/last run
- fail_elem  out  3  March element (0..5) of first mismatch
- fail_addr  out  ADDR_W  address of first mismatch
- fail_data  out  DATA_W  mem_dout value at first mismatch
- err_count  out  5  number of mismatching reads, saturates at 31

## Operation
- Algorithm (b = all-zeros, ~b = all-ones): E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
- Up elements address 0..3, down elements 3..0; in two-op elements both ops complete on one address before the address moves.
- FSM states: IDLE, RUN, DONE. IDLE -start-> RUN; RUN -last op of E5 (or first mismatch with STOP_ON_FAIL=1)-> DONE; DONE -start-> RUN. start in RUN is ignored.
- Accepting start clears fail, fail_elem/addr/data, err_count, done.
- Write op: mem_we=1, mem_din = element's write value.
- Read op: mem_we=0, mem_din=0; mem_dout compared against expected value; mismatch increments err_count, sets fail; fail_elem/addr/data captured only when fail was 0.
- Outside RUN: mem_we=0, mem_addr=0, mem_din=0.
- Reset (any time, incl. mid-test): state IDLE, all outputs 0, counters 0; no partial result survives.

## Timing
- All outputs registered; one March op per cycle, no stalls.
- start high at edge E -> op 1 driven in cycle after E, busy=1 same cycle.
- 40 ops total (E0: 4, E1-E4: 8 each, E5: 4); ops occupy cycles 1..40 after E.
- Write takes effect at the edge ending its op cycle; read comparison sampled at the edge ending its op cycle.
- Cycle 41: busy=0, done=1, fail/err_count final.
- STOP_ON_FAIL=1: mismatch at op n -> done=1, busy=0 in cycle n+1; no further ops.
- Mismatch on E5's last read is counted and captured before done rises.

## Structure
- Package mbist_pkg: FSM state enum, element index type, per-element constants (direction, op count, read value, write value), NUM_OPS=40.
- Sub-module mbist_addr_gen: up/down address counter with load/step and last-address flag; controller sequences elements and compares.

## Test plan
- Fault-free 4x4 SRAM model, start pulse -> busy cycles 1..40, done cycle 41, fail=0, err_count=0; write trace matches March C- order.
- Stuck-at-0 on addr 2 bit 1 -> fail=1, fail_elem=2, fail_addr=2, fail_data=4'b1101, err_count=2.
- Stuck-at-1 on addr 1 bit 0 -> fail_elem=1, fail_addr=1, fail_data=4'b0001, err_count=3.
- STOP_ON_FAIL=1 with stuck-at-1 addr 1 bit 0 -> first mismatch at op 7, done=1 in cycle 8, mem_we=0 thereafter, err_count=1.
- start pulses in cycles 5 and 20 of a run -> ignored; done still cycle 41.
- rst asserted in cycle 17 -> all outputs 0 immediately; new start -> full 40-op run, clean results.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and March C- element table for the SRAM built-in self-test controller.
package mbist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   typedef logic [2:0] elem_t;

   localparam elem_t LAST_ELEM = 3'd5;
   localparam int    NUM_OPS   = 40;

   // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
   function automatic logic elem_down(elem_t e);
      return (e == 3'd3) || (e == 3'd4);
   endfunction

   function automatic logic elem_has_read(elem_t e);
      return e != 3'd0;
   endfunction

   function automatic logic elem_has_write(elem_t e);
      return e != 3'd5;
   endfunction

   function automatic logic elem_read_val(elem_t e);
      return (e == 3'd2) || (e == 3'd4);
   endfunction

   function automatic logic elem_write_val(elem_t e);
      return (e == 3'd1) || (e == 3'd3);
   endfunction

   function automatic logic [3:0] elem_op_count(elem_t e);
      return (elem_has_read(e) && elem_has_write(e)) ? 4'd8 : 4'd4;
   endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down word address counter for the March sequencer, with load, step and last-address flag.
module mbist_addr_gen #(
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr,
   output logic              is_last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_val;
      end else if (step) begin
         addr <= down ? addr - 1'b1 : addr + 1'b1;
      end
   end

   assign is_last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: sequences the six elements over the SRAM, compares reads and records results.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 4,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [DATA_W-1:0] mem_din,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [2:0]        fail_elem,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [4:0]        err_count
);

   state_t            state;
   elem_t             elem;
   logic              phase;
   logic              addr_last;
   logic              cur_is_read;
   logic              last_op_here;
   logic              mismatch;
   logic              abort;
   logic              finish;
   elem_t             next_elem;
   logic              next_phase;
   logic              next_we;
   logic [DATA_W-1:0] next_din;
   logic              gen_load;
   logic [ADDR_W-1:0] gen_load_val;
   logic              gen_step;

   mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (gen_load),
      .load_val (gen_load_val),
      .step     (gen_step),
      .down     (elem_down(elem)),
      .addr     (mem_addr),
      .is_last  (addr_last)
   );

   // phase 0 is the read of a read-then-write element; single-op elements only use phase 0
   assign cur_is_read  = elem_has_read(elem) && !phase;
   assign last_op_here = phase || !(elem_has_read(elem) && elem_has_write(elem));
   assign mismatch     = (state == ST_RUN) && cur_is_read &&
                         (mem_dout != {DATA_W{elem_read_val(elem)}});
   assign abort        = mismatch && STOP_ON_FAIL;
   assign finish       = last_op_here && addr_last && (elem == LAST_ELEM);

   // The address counter is parked at 0 whenever the next cycle is not a March op
   always_comb begin
      next_elem    = elem;
      next_phase   = 1'b0;
      gen_load     = 1'b1;
      gen_load_val = '0;
      gen_step     = 1'b0;
      if (state == ST_RUN && !abort && !finish) begin
         gen_load = 1'b0;
         if (!last_op_here) begin
            next_phase = 1'b1;
         end else if (!addr_last) begin
            gen_step = 1'b1;
         end else begin
            next_elem    = elem + 3'd1;
            gen_load     = 1'b1;
            gen_load_val = elem_down(next_elem) ? '1 : '0;
         end
      end
      next_we  = !(elem_has_read(next_elem) && !next_phase);
      next_din = next_we ? {DATA_W{elem_write_val(next_elem)}} : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         elem      <= '0;
         phase     <= 1'b0;
         mem_we    <= 1'b0;
         mem_din   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_elem <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         err_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_RUN;
                  elem      <= '0;
                  phase     <= 1'b0;
                  mem_we    <= !elem_has_read('0);
                  mem_din   <= {DATA_W{elem_write_val('0)}};
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  fail      <= 1'b0;
                  fail_elem <= '0;
                  fail_addr <= '0;
                  fail_data <= '0;
                  err_count <= '0;
               end
            end
            ST_RUN: begin
               if (mismatch) begin
                  if (err_count != 5'd31) begin
                     err_count <= err_count + 5'd1;
                  end
                  fail <= 1'b1;
                  if (!fail) begin
                     fail_elem <= elem;
                     fail_addr <= mem_addr;
                     fail_data <= mem_dout;
                  end
               end
               if (finish || abort) begin
                  state   <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  mem_we  <= 1'b0;
                  mem_din <= '0;
               end else begin
                  elem    <= next_elem;
                  phase   <= next_phase;
                  mem_we  <= next_we;
                  mem_din <= next_din;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
